// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: line levels, data width and receiver state encoding.
// The transmit side uses the same constants so both ends agree on framing.
package uart_rx_pkg;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic IDLE_BIT  = 1'b1;

    localparam int UART_DATA_W = 8;

    // Synchronizer depth, and how many consecutive idle samples WAIT_IDLE needs
    // before arming: one more than the depth, so reset-valued flops cannot fake an idle line.
    localparam int SYNC_STAGES      = 2;
    localparam int WAIT_IDLE_CYCLES = SYNC_STAGES + 1;

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
        STOP
    } uart_rx_state_t;

    // LSB-first reception: each new bit enters at the MSB and the word shifts right.
    function automatic logic [UART_DATA_W-1:0] shift_in_msb(
        input logic [UART_DATA_W-1:0] cur,
        input logic                   bit_in
    );
        return {bit_in, cur[UART_DATA_W-1:1]};
    endfunction

endpackage

// File: rtl/rv_if.sv
// Valid/ready streaming channel. TX drives valid/data, RX drives ready.
interface rv_if #(
    parameter int W = 8
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport TX (output valid, output data, input ready);
    modport RX (input valid, input data, output ready);
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs, one independent chain per bit.
// Both stages take RESET_VAL on reset so the output starts at a known level.
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic meta_reg;
        logic sync_reg;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                meta_reg <= RESET_VAL[gi];
                sync_reg <= RESET_VAL[gi];
            end else begin
                meta_reg <= d[gi];
                sync_reg <= meta_reg;
            end
        end

        assign q[gi] = sync_reg;
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling of the synchronized line, bytes returned
// through a one-entry holding register on a valid/ready channel.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic clk,
    input  logic rst,
    input  logic serial_in,
    rv_if.TX     recv_resp,
    output logic frame_err,
    output logic overrun
);

    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
    localparam int CNT_W            = $clog2(SYMBOL_EDGE_TIME);

    localparam logic [CNT_W-1:0] SYMBOL_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_TIME - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(WAIT_IDLE_CYCLES - 1);
    localparam logic [2:0]       LAST_BIT    = 3'(UART_DATA_W - 1);

    uart_rx_state_t         state_reg;
    logic [CNT_W-1:0]       clk_cnt_reg;
    logic [2:0]             bit_cnt_reg;
    logic [UART_DATA_W-1:0] shift_reg;
    logic [UART_DATA_W-1:0] data_reg;
    logic                   valid_reg;

    logic rx_s;
    logic sample_tick;
    logic stop_ok;
    logic pop;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (serial_in),
        .q   (rx_s)
    );

    assign sample_tick = (clk_cnt_reg == SYMBOL_LAST);
    assign stop_ok     = (state_reg == STOP) && sample_tick && (rx_s == STOP_BIT);
    assign pop         = valid_reg && recv_resp.ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= WAIT_IDLE;
            clk_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            frame_err   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state_reg)
                // Counts consecutive idle samples; any low sample restarts the count.
                WAIT_IDLE: begin
                    if (rx_s == IDLE_BIT) begin
                        if (clk_cnt_reg == WAIT_LAST) begin
                            state_reg   <= IDLE;
                            clk_cnt_reg <= '0;
                        end else begin
                            clk_cnt_reg <= clk_cnt_reg + 1'b1;
                        end
                    end else begin
                        clk_cnt_reg <= '0;
                    end
                end
                IDLE: begin
                    if (rx_s == START_BIT) begin
                        state_reg   <= START;
                        clk_cnt_reg <= '0;
                    end
                end
                // A start bit that has gone high again by mid-bit is treated as noise.
                START: begin
                    if (clk_cnt_reg == SAMPLE_LAST) begin
                        clk_cnt_reg <= '0;
                        if (rx_s == START_BIT) begin
                            state_reg   <= DATA;
                            bit_cnt_reg <= '0;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + 1'b1;
                    end
                end
                DATA: begin
                    if (sample_tick) begin
                        clk_cnt_reg <= '0;
                        shift_reg   <= shift_in_msb(shift_reg, rx_s);
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        if (bit_cnt_reg == LAST_BIT) begin
                            state_reg <= STOP;
                        end
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + 1'b1;
                    end
                end
                // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start edge.
                STOP: begin
                    if (sample_tick) begin
                        clk_cnt_reg <= '0;
                        if (rx_s == STOP_BIT) begin
                            state_reg <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state_reg <= WAIT_IDLE;
                        end
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg   <= WAIT_IDLE;
                    clk_cnt_reg <= '0;
                end
            endcase
        end
    end

    // Holding register: a new byte may replace one being popped in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
            overrun   <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (stop_ok) begin
                if (!valid_reg || pop) begin
                    data_reg  <= shift_reg;
                    valid_reg <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (pop) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign recv_resp.valid = valid_reg;
    assign recv_resp.data  = data_reg;

endmodule
